trace_dump: RTL and testbench

Reads a completed 512-sample trace out of the capture RAM in chronological order and streams it, one byte at a time, to the UART transmitter. It is the read-side partner of the capture engine. Once capture has finished and a dump command arrives, it reads from the entry after the final write address, wraps around the circular buffer, and hands each sample to the transmitter. After the last byte it clears the capture-done flag so the engine can re-arm.

---
 rtl/trace_dump.sv | 110 +++++++++++
 tb/tb_trace_dump.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_dump.sv
// Read-side partner of the capture engine: replays a finished circular trace in
// chronological order, one byte per UART frame, then clears the capture-done flag.
module trace_dump #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dump_start,
  input  logic              dump_abort,
  input  logic              capture_done,
  input  logic [ADDR_W-1:0] trace_end,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_en,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] tx_data,
  output logic              trmt,
  input  logic              tx_done,
  output logic              busy,
  output logic              dump_done,
  output logic              clr_capture_done,
  output logic [2:0]        state_dbg
);

  // Handshake to the UART: trmt is a one-cycle start strobe with tx_data held
  // stable until the next LATCH; tx_done is a one-cycle completion strobe that
  // only counts in WAIT_TX once trmt has dropped.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    LATCH   = 3'd2,
    WAIT_TX = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

  state_t          state;
  logic [ADDR_W:0] sent_cnt;
  logic            tx_done_ok;
  logic            last_byte;

  // A tx_done coinciding with our own trmt belongs to an earlier byte.
  assign tx_done_ok = tx_done && !trmt;
  assign last_byte  = (sent_cnt == LAST_CNT);

  assign ram_en    = (state == RD);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      ram_addr         <= '0;
      tx_data          <= '0;
      sent_cnt         <= '0;
      trmt             <= 1'b0;
      dump_done        <= 1'b0;
      clr_capture_done <= 1'b0;
    end else begin
      trmt             <= 1'b0;
      dump_done        <= 1'b0;
      clr_capture_done <= 1'b0;
      if (dump_abort && state != IDLE) begin
        // Abort leaves tx_data/ram_addr untouched and never signals completion.
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (dump_start && capture_done) begin
              // Oldest sample sits just past the final write address.
              ram_addr <= trace_end + ADDR_W'(1);
              sent_cnt <= '0;
              state    <= RD;
            end
          end
          RD: begin
            state <= LATCH;
          end
          LATCH: begin
            tx_data <= ram_rdata;
            trmt    <= 1'b1;
            state   <= WAIT_TX;
          end
          WAIT_TX: begin
            if (tx_done_ok) begin
              sent_cnt <= sent_cnt + (ADDR_W+1)'(1);
              ram_addr <= ram_addr + ADDR_W'(1);
              if (last_byte) begin
                dump_done        <= 1'b1;
                clr_capture_done <= 1'b1;
                state            <= DONE;
              end else begin
                state <= RD;
              end
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trace_dump.sv
// Directed bench for trace_dump: synchronous RAM model, cycle-driven UART
// responder, and queue-based scoreboard of bytes and read addresses.
module tb_trace_dump;

  localparam int DEPTH  = 512;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;

  logic              clk;
  logic              rst_n;
  logic              dump_start;
  logic              dump_abort;
  logic              capture_done;
  logic [ADDR_W-1:0] trace_end;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_en;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] tx_data;
  logic              trmt;
  logic              tx_done;
  logic              busy;
  logic              dump_done;
  logic              clr_capture_done;
  logic [2:0]        state_dbg;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] got_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  int done_cnt = 0;
  int clr_cnt  = 0;

  trace_dump #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .dump_start(dump_start), .dump_abort(dump_abort),
    .capture_done(capture_done), .trace_end(trace_end), .ram_addr(ram_addr),
    .ram_en(ram_en), .ram_rdata(ram_rdata), .tx_data(tx_data), .trmt(trmt),
    .tx_done(tx_done), .busy(busy), .dump_done(dump_done),
    .clr_capture_done(clr_capture_done), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read trace RAM: data valid the cycle after ram_en.
  always @(posedge clk) begin
    if (ram_en) ram_rdata <= mem[ram_addr];
  end

  // Monitor: collects what the DUT emits; tests compare against expectations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (trmt)             got_q.push_back(tx_data);
      if (ram_en)           addr_q.push_back(ram_addr);
      if (dump_done)        done_cnt++;
      if (clr_capture_done) clr_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_monitor();
    got_q.delete();
    addr_q.delete();
    done_cnt = 0;
    clr_cnt  = 0;
  endtask

  task automatic build_expected(input logic [ADDR_W-1:0] te);
    logic [ADDR_W-1:0] a;
    exp_q.delete();
    exp_addr_q.delete();
    a = te;
    for (int i = 0; i < DEPTH; i++) begin
      a = a + 9'd1;
      exp_addr_q.push_back(a);
      exp_q.push_back(a[7:0]);
    end
  endtask

  // Leaves the caller at the falling edge of the cycle after the accept edge.
  task automatic start_dump(input logic [ADDR_W-1:0] te);
    @(negedge clk);
    trace_end    = te;
    capture_done = 1'b1;
    dump_start   = 1'b1;
    @(negedge clk);
    dump_start   = 1'b0;
  endtask

  // Answers n trmt pulses with a tx_done dly cycles later; stops early on timeout.
  task automatic serve_bytes(input int n, input int dly, output int served);
    served = 0;
    for (int b = 0; b < n; b++) begin
      int w = 0;
      while (trmt !== 1'b1 && w < 10) begin
        @(negedge clk);
        w++;
      end
      if (trmt !== 1'b1) return;
      repeat (dly) @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      served++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, ram_en, trmt, dump_done, clr_capture_done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000", {busy, ram_en, trmt, dump_done, clr_capture_done});
    end
    checks++;
    if (ram_addr !== 9'h000 || tx_data !== 8'h00 || state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL reset_regs: addr=%h data=%h state=%0d expected 000/00/0", ram_addr, tx_data, state_dbg);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_gating();
    clear_monitor();
    capture_done = 1'b0;
    trace_end    = 9'h010;
    dump_start   = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || addr_q.size() != 0 || got_q.size() != 0) begin
      errors++;
      $display("FAIL gate_no_capture: busy=%b reads=%0d trmts=%0d expected 0/0/0", busy, addr_q.size(), got_q.size());
    end
    // tx_done while idle must be ignored.
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || state_dbg !== 3'd0 || got_q.size() != 0) begin
      errors++;
      $display("FAIL idle_tx_done: busy=%b state=%0d trmts=%0d expected 0/0/0", busy, state_dbg, got_q.size());
    end
  endtask

  task automatic test_wrap_top();
    int served;
    int bad;
    clear_monitor();
    build_expected(9'h1FF);
    start_dump(9'h1FF);
    checks++;
    if (ram_en !== 1'b1 || busy !== 1'b1 || ram_addr !== 9'h000) begin
      errors++;
      $display("FAIL wrap_first_read: ram_en=%b busy=%b addr=%h expected 1/1/000", ram_en, busy, ram_addr);
    end
    @(negedge clk);
    checks++;
    if (ram_en !== 1'b0 || trmt !== 1'b0 || state_dbg !== 3'd2) begin
      errors++;
      $display("FAIL wrap_latch: ram_en=%b trmt=%b state=%0d expected 0/0/2", ram_en, trmt, state_dbg);
    end
    @(negedge clk);
    checks++;
    if (trmt !== 1'b1 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL wrap_first_trmt: trmt=%b tx_data=%h expected 1/00", trmt, tx_data);
    end
    serve_bytes(DEPTH, 20, served);
    checks++;
    if (served != DEPTH) begin
      errors++;
      $display("FAIL wrap_timeout: served %0d expected %0d", served, DEPTH);
    end
    checks++;
    if (dump_done !== 1'b1 || clr_capture_done !== 1'b1) begin
      errors++;
      $display("FAIL wrap_done_pulse: dump_done=%b clr=%b expected 1/1", dump_done, clr_capture_done);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dump_done !== 1'b0) begin
      errors++;
      $display("FAIL wrap_idle_after: busy=%b dump_done=%b expected 0/0", busy, dump_done);
    end
    bad = 0;
    if (got_q.size() == DEPTH && addr_q.size() == DEPTH)
      for (int i = 0; i < DEPTH; i++)
        if (got_q[i] !== exp_q[i] || addr_q[i] !== exp_addr_q[i]) bad++;
    checks++;
    if (got_q.size() != DEPTH || addr_q.size() != DEPTH || bad != 0 || done_cnt != 1 || clr_cnt != 1) begin
      errors++;
      $display("FAIL wrap_stream: bytes=%0d reads=%0d bad=%0d done=%0d clr=%0d expected 512/512/0/1/1",
               got_q.size(), addr_q.size(), bad, done_cnt, clr_cnt);
    end
  endtask

  task automatic test_mid_buffer();
    int served;
    int served2;
    int bad;
    clear_monitor();
    build_expected(9'h0A5);
    start_dump(9'h0A5);
    serve_bytes(10, 3, served);
    // A second request while busy, with a different trace_end, must not restart.
    trace_end  = 9'h000;
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    trace_end  = 9'h0A5;
    serve_bytes(DEPTH - 10, 3, served2);
    checks++;
    if (served + served2 != DEPTH || dump_done !== 1'b1) begin
      errors++;
      $display("FAIL mid_count: served %0d dump_done=%b expected 512/1", served + served2, dump_done);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (got_q.size() != DEPTH || got_q[0] !== 8'hA6 || got_q[DEPTH-1] !== 8'hA5) begin
      errors++;
      $display("FAIL mid_first_last: bytes=%0d first=%h last=%h expected 512/a6/a5",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 8'h00, got_q.size() > 0 ? got_q[got_q.size()-1] : 8'h00);
    end
    bad = 0;
    if (got_q.size() == DEPTH && addr_q.size() == DEPTH)
      for (int i = 0; i < DEPTH; i++)
        if (got_q[i] !== exp_q[i] || addr_q[i] !== exp_addr_q[i]) bad++;
    checks++;
    if (addr_q.size() != DEPTH || bad != 0 || done_cnt != 1 || clr_cnt != 1) begin
      errors++;
      $display("FAIL mid_stream: reads=%0d bad=%0d done=%0d clr=%0d expected 512/0/1/1",
               addr_q.size(), bad, done_cnt, clr_cnt);
    end
  endtask

  task automatic test_stale_tx_done();
    clear_monitor();
    start_dump(9'h050);
    repeat (2) @(negedge clk);
    // tx_done in the trmt cycle must be ignored.
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (state_dbg !== 3'd3 || addr_q.size() != 1 || got_q.size() != 1) begin
      errors++;
      $display("FAIL stale_ignored: state=%0d reads=%0d trmts=%0d expected 3/1/1", state_dbg, addr_q.size(), got_q.size());
    end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    checks++;
    if (state_dbg !== 3'd1 || ram_en !== 1'b1 || ram_addr !== 9'h052) begin
      errors++;
      $display("FAIL stale_advance: state=%0d ram_en=%b addr=%h expected 1/1/052", state_dbg, ram_en, ram_addr);
    end
    dump_abort = 1'b1;
    @(negedge clk);
    dump_abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done_cnt != 0) begin
      errors++;
      $display("FAIL stale_cleanup: busy=%b done=%0d expected 0/0", busy, done_cnt);
    end
  endtask

  task automatic test_abort();
    int served;
    int w;
    int bad;
    clear_monitor();
    start_dump(9'h1F0);
    serve_bytes(99, 3, served);
    w = 0;
    while (trmt !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (served != 99 || trmt !== 1'b1) begin
      errors++;
      $display("FAIL abort_reach_100: served=%0d trmt=%b expected 99/1", served, trmt);
    end
    dump_abort = 1'b1;
    @(negedge clk);
    dump_abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || state_dbg !== 3'd0 || tx_data !== 8'h54 || ram_addr !== 9'h054) begin
      errors++;
      $display("FAIL abort_idle: busy=%b state=%0d tx_data=%h addr=%h expected 0/0/54/054",
               busy, state_dbg, tx_data, ram_addr);
    end
    // The in-flight byte finishes on the UART; that tx_done lands in IDLE.
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (got_q.size() != 100 || done_cnt != 0 || clr_cnt != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet: trmts=%0d done=%0d clr=%0d busy=%b expected 100/0/0/0",
               got_q.size(), done_cnt, clr_cnt, busy);
    end
    clear_monitor();
    build_expected(9'h1F0);
    start_dump(9'h1F0);
    serve_bytes(DEPTH, 3, served);
    repeat (2) @(negedge clk);
    bad = 0;
    if (got_q.size() == DEPTH && addr_q.size() == DEPTH)
      for (int i = 0; i < DEPTH; i++)
        if (got_q[i] !== exp_q[i] || addr_q[i] !== exp_addr_q[i]) bad++;
    checks++;
    if (served != DEPTH || got_q.size() != DEPTH || bad != 0 || done_cnt != 1 || clr_cnt != 1) begin
      errors++;
      $display("FAIL abort_retry: served=%0d bytes=%0d bad=%0d done=%0d clr=%0d expected 512/512/0/1/1",
               served, got_q.size(), bad, done_cnt, clr_cnt);
    end
  endtask

  task automatic test_reset_mid_dump();
    int served;
    int w;
    int bad;
    clear_monitor();
    start_dump(9'h123);
    serve_bytes(299, 3, served);
    w = 0;
    while (trmt !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, ram_en, trmt, dump_done, clr_capture_done} !== 5'b0 ||
        ram_addr !== 9'h000 || tx_data !== 8'h00 || state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid: ctrl=%b addr=%h data=%h state=%0d expected 00000/000/00/0",
               {busy, ram_en, trmt, dump_done, clr_capture_done}, ram_addr, tx_data, state_dbg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_monitor();
    build_expected(9'h123);
    start_dump(9'h123);
    serve_bytes(DEPTH, 3, served);
    repeat (2) @(negedge clk);
    bad = 0;
    if (got_q.size() == DEPTH && addr_q.size() == DEPTH)
      for (int i = 0; i < DEPTH; i++)
        if (got_q[i] !== exp_q[i] || addr_q[i] !== exp_addr_q[i]) bad++;
    checks++;
    if (served != DEPTH || got_q.size() != DEPTH || bad != 0 || done_cnt != 1 || clr_cnt != 1) begin
      errors++;
      $display("FAIL reset_redump: served=%0d bytes=%0d bad=%0d done=%0d clr=%0d expected 512/512/0/1/1",
               served, got_q.size(), bad, done_cnt, clr_cnt);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
    rst_n        = 1'b0;
    dump_start   = 1'b0;
    dump_abort   = 1'b0;
    capture_done = 1'b0;
    trace_end    = '0;
    tx_done      = 1'b0;
    ram_rdata    = '0;
    test_reset();
    test_gating();
    test_wrap_top();
    test_mid_buffer();
    test_stale_tx_done();
    test_abort();
    test_reset_mid_dump();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
